// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the operand-fetch stage.
//   NUM_REGS    : architectural GPR count
//   XLEN        : register / data width
//   REG_IDX_W   : register index width
//   reg_idx_t   : register index type
//   issue_pkt_t : packet held in the fetch->execute output register
//   idx_mask()  : one-hot register mask, all-zero when the enable is low
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int NUM_REGS  = 16;
  localparam int XLEN      = 64;
  localparam int REG_IDX_W = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    logic [XLEN-1:0] rip;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    reg_idx_t        dest;
    logic            dest_valid;
    reg_idx_t        dest_special;
    logic            dest_special_valid;
  } issue_pkt_t;

  // One-hot mask of a register index, or zero when the reference is not valid.
  function automatic logic [NUM_REGS-1:0] idx_mask(input reg_idx_t idx, input logic en);
    logic [NUM_REGS-1:0] m;
    m = '0;
    if (en) m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// One pending-writer bit per architectural register.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   set_vec_in        : bits to mark busy this cycle (instruction issue)
//   clr_vec_in        : bits to release this cycle (write-back / flush)
//   busy_map_out      : current busy map, bit n = register n has a writer
// A bit that is both set and cleared in the same cycle ends up set: the new
// writer is younger than the one retiring.
// ---------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REGS-1:0] set_vec_in,
  input  logic [NUM_REGS-1:0] clr_vec_in,
  output logic [NUM_REGS-1:0] busy_map_out
);

  logic [NUM_REGS-1:0] r_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~clr_vec_in) | set_vec_in;
    end
  end

  assign busy_map_out = r_busy;

endmodule

// File: rtl/operand_fetch.sv
// ---------------------------------------------------------------------------
// operand_fetch
// Register-read / issue stage: owns the GPR file and the busy scoreboard,
// stalls on RAW/WAW hazards and hands one instruction at a time to execute.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. Decode's instruction is taken when
// dec_ready_out is high (dec_ready_out already includes dec_valid_in). The
// execute side holds ex_valid_out and every ex_* field stable until
// ex_ready_in is seen high, or until flush_in squashes the held instruction.
//
// Ports:
//   clk, reset_n                    : clock, asynchronous active-low reset
//   dec_valid_in / dec_ready_out    : decode handshake
//   dec_rip_in                      : instruction RIP
//   src1/src2_in, src*_valid_in     : source register references
//   dest*_in, dest*_valid_in        : normal and special destinations
//   ex_valid_out / ex_ready_in      : execute handshake
//   ex_rip_out, op1_out, op2_out    : issued RIP and operand values
//   dest*_out, dest*_valid_out      : issued destinations
//   wb_* / wb_special_*             : two write-back ports (special wins on
//                                     a same-register collision)
//   flush_in                        : squash the held instruction
//   busy_map_out                    : scoreboard, bit n = pending writer
//
// Build option: define WB_BYPASS_EN to let a register being written back
// this cycle satisfy a hazard in the same cycle, with its write-back data
// forwarded into the operand. Without it, the write lands in the register
// file and the instruction issues on the following cycle.
// ---------------------------------------------------------------------------
module operand_fetch #(
  parameter int NUM_REGS = fetch_pkg::NUM_REGS,
  parameter int XLEN     = fetch_pkg::XLEN
) (
  input  logic                clk,
  input  logic                reset_n,
  // decode side
  input  logic                dec_valid_in,
  output logic                dec_ready_out,
  input  logic [XLEN-1:0]     dec_rip_in,
  input  fetch_pkg::reg_idx_t src1_in,
  input  logic                src1_valid_in,
  input  fetch_pkg::reg_idx_t src2_in,
  input  logic                src2_valid_in,
  input  fetch_pkg::reg_idx_t dest_in,
  input  logic                dest_valid_in,
  input  fetch_pkg::reg_idx_t dest_special_in,
  input  logic                dest_special_valid_in,
  // execute side
  output logic                ex_valid_out,
  input  logic                ex_ready_in,
  output logic [XLEN-1:0]     ex_rip_out,
  output logic [XLEN-1:0]     op1_out,
  output logic [XLEN-1:0]     op2_out,
  output fetch_pkg::reg_idx_t dest_out,
  output logic                dest_valid_out,
  output fetch_pkg::reg_idx_t dest_special_out,
  output logic                dest_special_valid_out,
  // write-back
  input  logic                wb_valid_in,
  input  fetch_pkg::reg_idx_t wb_dest_in,
  input  logic [XLEN-1:0]     wb_data_in,
  input  logic                wb_special_valid_in,
  input  fetch_pkg::reg_idx_t wb_dest_special_in,
  input  logic [XLEN-1:0]     wb_data_special_in,
  // control / status
  input  logic                flush_in,
  output logic [NUM_REGS-1:0] busy_map_out
);

  import fetch_pkg::reg_idx_t;
  import fetch_pkg::issue_pkt_t;
  import fetch_pkg::idx_mask;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [XLEN-1:0] r_regs [NUM_REGS];
  issue_pkt_t      r_pkt;
  logic            r_ex_valid;

  // -------------------------------------------------------------------------
  // Combinational
  // -------------------------------------------------------------------------
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_busy_eff;
  logic [NUM_REGS-1:0] w_wb_clr_vec;
  logic [NUM_REGS-1:0] w_flush_clr_vec;
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_clr_vec;
  logic                w_slot_free;
  logic                w_hazard;
  logic                w_accept;
  logic [XLEN-1:0]     w_op1;
  logic [XLEN-1:0]     w_op2;
  issue_pkt_t          w_next_pkt;

  // Operand read; a source that is not referenced reads as zero.
  function automatic logic [XLEN-1:0] read_operand(input reg_idx_t idx, input logic en);
    logic [XLEN-1:0] v;
    v = '0;
    if (en) begin
      v = r_regs[idx];
`ifdef WB_BYPASS_EN
      // Forward this cycle's write-back; special port has priority, matching
      // the register-file write order.
      if (wb_special_valid_in && (wb_dest_special_in == idx)) begin
        v = wb_data_special_in;
      end else if (wb_valid_in && (wb_dest_in == idx)) begin
        v = wb_data_in;
      end
`endif
    end
    return v;
  endfunction

  assign w_wb_clr_vec = idx_mask(wb_dest_in, wb_valid_in)
                      | idx_mask(wb_dest_special_in, wb_special_valid_in);

  // A squashed instruction will never write back, so release its registers.
  assign w_flush_clr_vec = (flush_in && r_ex_valid)
                         ? (idx_mask(r_pkt.dest, r_pkt.dest_valid)
                          | idx_mask(r_pkt.dest_special, r_pkt.dest_special_valid))
                         : '0;

`ifdef WB_BYPASS_EN
  assign w_busy_eff = w_busy & ~w_wb_clr_vec;
`else
  // Bits being cleared this cycle still count as busy; the data is only
  // readable from the register file next cycle.
  assign w_busy_eff = w_busy;
`endif

  assign w_hazard = (src1_valid_in         && w_busy_eff[src1_in])
                 || (src2_valid_in         && w_busy_eff[src2_in])
                 || (dest_valid_in         && w_busy_eff[dest_in])
                 || (dest_special_valid_in && w_busy_eff[dest_special_in]);

  assign w_slot_free = !r_ex_valid || ex_ready_in;
  assign w_accept    = dec_valid_in && w_slot_free && !w_hazard && !flush_in;

  assign w_op1 = read_operand(src1_in, src1_valid_in);
  assign w_op2 = read_operand(src2_in, src2_valid_in);

  always_comb begin
    w_next_pkt                    = '0;
    w_next_pkt.rip                = dec_rip_in;
    w_next_pkt.op1                = w_op1;
    w_next_pkt.op2                = w_op2;
    w_next_pkt.dest               = dest_in;
    w_next_pkt.dest_valid         = dest_valid_in;
    w_next_pkt.dest_special       = dest_special_in;
    w_next_pkt.dest_special_valid = dest_special_valid_in;
  end

  // Identical dest codes collapse into one bit through the OR.
  assign w_set_vec = w_accept
                   ? (idx_mask(dest_in, dest_valid_in)
                    | idx_mask(dest_special_in, dest_special_valid_in))
                   : '0;
  assign w_clr_vec = w_wb_clr_vec | w_flush_clr_vec;

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk          (clk),
    .reset_n      (reset_n),
    .set_vec_in   (w_set_vec),
    .clr_vec_in   (w_clr_vec),
    .busy_map_out (w_busy)
  );

  // -------------------------------------------------------------------------
  // Register file: the special port is written last so it wins a collision.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (wb_valid_in) begin
        r_regs[wb_dest_in] <= wb_data_in;
      end
      if (wb_special_valid_in) begin
        r_regs[wb_dest_special_in] <= wb_data_special_in;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Issue register. Accept excludes flush, and a held-but-unconsumed packet
  // blocks accept, so the fields only change on a real transfer.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_valid <= 1'b0;
      r_pkt      <= '0;
    end else if (w_accept) begin
      r_ex_valid <= 1'b1;
      r_pkt      <= w_next_pkt;
    end else if (flush_in || ex_ready_in) begin
      r_ex_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. dec_ready_out is combinational, so it is gated by reset to keep
  // every output at zero while reset is asserted.
  // -------------------------------------------------------------------------
  assign dec_ready_out          = w_accept && reset_n;
  assign ex_valid_out           = r_ex_valid;
  assign ex_rip_out             = r_pkt.rip;
  assign op1_out                = r_pkt.op1;
  assign op2_out                = r_pkt.op2;
  assign dest_out               = r_pkt.dest;
  assign dest_valid_out         = r_pkt.dest_valid;
  assign dest_special_out       = r_pkt.dest_special;
  assign dest_special_valid_out = r_pkt.dest_special_valid;
  assign busy_map_out           = w_busy;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter NUM_REGS, default 16: architectural GPR count; index width 4.
REQ-002 Parameter XLEN, default 64: register and data width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 dec_valid_in  in  1  decode offers an instruction.
REQ-006 dec_ready_out  out  1  instruction accepted this cycle when high with dec_valid_in.
REQ-007 dec_rip_in  in  64  instruction RIP.
REQ-008 src1_in/src2_in  in  4 each  source register codes; src1_valid_in/src2_valid_in  in  1 each.
REQ-009 dest_in  in  4; dest_valid_in  in  1; dest_special_in  in  4; dest_special_valid_in  in  1  destinations.
REQ-010 ex_valid_out  out  1; ex_ready_in  in  1  execute-side handshake.
REQ-011 ex_rip_out  out  64; op1_out/op2_out  out  64 each; dest/dest_special codes and valids out, mirroring the inputs.
REQ-012 wb_valid_in  in  1; wb_dest_in  in  4; wb_data_in  in  64; wb_special_valid_in  in  1; wb_dest_special_in  in  4; wb_data_special_in  in  64  write-back port.
REQ-013 flush_in  in  1  squash the held instruction.
REQ-014 busy_map_out  out  16  scoreboard, bit n = register n has a pending writer.

Function
REQ-015 Block SHALL own a 16x64 register file and a 16-bit scoreboard.
REQ-016 Hazard = any valid source busy, or any valid destination busy (WAW).
REQ-017 slot_free = !ex_valid_out || ex_ready_in; dec_ready_out = dec_valid_in && slot_free && !hazard && !flush_in.
REQ-018 On accept: output register loads RIP, operands (regfile read; invalid source yields 0), dest fields; ex_valid_out=1 next cycle; latency 1.
REQ-019 On accept: scoreboard bits of valid dest and dest_special SHALL be set; identical codes set one bit.
REQ-020 Held output SHALL stay stable while ex_valid_out && !ex_ready_in.
REQ-021 ex_valid_out clears when consumed with no new accept.
REQ-022 wb_valid_in writes wb_data_in to wb_dest_in and clears its bit; wb_special_valid_in does likewise for the special port; both same register: special data wins.
REQ-023 Same-cycle set (accept) and clear (write-back) of one bit: set wins.
REQ-024 flush_in: ex_valid_out=0 next cycle; scoreboard bits of the held instruction's valid dests cleared; no accept; flush outranks ex_ready_in.
REQ-025 Without bypass, write-back data is visible to reads from the following cycle; a busy bit being cleared this cycle still stalls.

Reset
REQ-026 reset_n low: regfile all zero, scoreboard 0, ex_valid_out 0, all data/code outputs 0, effective immediately, mid-transaction state discarded.

Configuration
REQ-027 WB_BYPASS_EN defined: a register cleared by write-back this cycle is not busy for the hazard check, and its wb data (special port if both match) is forwarded to op1_out/op2_out.
REQ-028 WB_BYPASS_EN undefined: REQ-025 applies; no forwarding path.

Structure
REQ-029 Package fetch_pkg SHALL hold NUM_REGS, XLEN, reg_idx_t (4-bit), and the issue-packet struct (rip, op1, op2, dest fields).
REQ-030 Scoreboard SHALL be a sub-module reg_scoreboard (set/clear vectors in, 16-bit map out).

Verification
REQ-031 Reset, issue src1=R1,dest=R2, R1=0 -> next cycle ex_valid_out=1, op1_out=0, busy_map_out=0x0004.
REQ-032 R2 busy; issue src1=R2; wb R2=0xDEAD -> stall until cycle after wb, op1_out=0xDEAD; with WB_BYPASS_EN, accepted in the wb cycle.
REQ-033 ex_ready_in=0 three cycles with new dec_valid_in -> outputs stable, dec_ready_out=0; ready=1 -> next instruction loads.
REQ-034 Held instruction dest=R5, flush_in=1 -> ex_valid_out=0, bit 5 clear, no accept that cycle.
REQ-035 Accept dest=R3 while wb clears R3 -> bit 3 remains set; wb data written to R3.
REQ-036 reset_n low mid-stall with busy_map_out=0xFFFF -> all outputs 0 asynchronously.
